// File: rtl/digit_stream_ser.sv
// rtl/digit_stream_ser.sv - paced serializer of a digit snapshot into key tokens with group separators
// Optional feature macro: DIGIT_STREAM_SER_CLEAR_EN (prepends CLEAR_CODE token to every stream)

module digit_stream_ser #(
    parameter int DIGIT_W     = 4,
    parameter int GROUP_LEN   = 5,
    parameter int NUM_GROUPS  = 4,
    parameter int PACE_CYCLES = 250000,
    parameter int MSB_FIRST   = 0,
    parameter int SEP_BASE    = 10,
    parameter int CLEAR_CODE  = 13
) (
    input  logic                                      Clk,
    input  logic                                      Rst_n,
    input  logic                                      Start,
    input  logic                                      Load,
    input  logic [DIGIT_W*GROUP_LEN*NUM_GROUPS-1:0]   Load_Data,
    output logic                                      Key_Flag,
    output logic [DIGIT_W-1:0]                        Key_Value,
    output logic                                      Busy,
    output logic                                      Loaded,
    output logic                                      Stream_Done
);

    localparam int NUM_DIGITS = GROUP_LEN * NUM_GROUPS;
    localparam int CNT_W  = $clog2(PACE_CYCLES);
    localparam int DIDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int POS_W  = (GROUP_LEN > 1)  ? $clog2(GROUP_LEN)  : 1;
    localparam int GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    if ((SEP_BASE + NUM_GROUPS - 2 > 2**DIGIT_W - 1) ||
        (CLEAR_CODE > 2**DIGIT_W - 1) || (PACE_CYCLES < 2)) begin : g_illegal_params
        $error("digit_stream_ser: illegal parameter setting");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [DIDX_W-1:0]               dig_q;
    logic [POS_W-1:0]                pos_q;
    logic [GRP_W-1:0]                grp_q;
    logic                            sep_pend_q;
    logic [DIGIT_W*NUM_DIGITS-1:0]   snap_q;
`ifdef DIGIT_STREAM_SER_CLEAR_EN
    logic                            clr_pend_q;
`endif

    logic [DIDX_W-1:0]  sel_d;
    logic [DIGIT_W-1:0] token_d;
    logic               last_d;
    logic               wrap_d;

    assign Busy   = (state_q == S_RUN);
    assign wrap_d = (cnt_q == CNT_W'(PACE_CYCLES - 1));

    // Token selection: the clear token outranks a pending separator, which outranks the next digit.
    always_comb begin
        sel_d   = (MSB_FIRST != 0) ? (DIDX_W'(NUM_DIGITS - 1) - dig_q) : dig_q;
        token_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_d == DIDX_W'(i)) token_d = snap_q[i*DIGIT_W +: DIGIT_W];
        end
        last_d = (dig_q == DIDX_W'(NUM_DIGITS - 1));
        if (sep_pend_q) begin
            token_d = DIGIT_W'(SEP_BASE) + DIGIT_W'(grp_q);
            last_d  = 1'b0;
        end
`ifdef DIGIT_STREAM_SER_CLEAR_EN
        if (clr_pend_q) begin
            token_d = DIGIT_W'(CLEAR_CODE);
            last_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dig_q       <= '0;
            pos_q       <= '0;
            grp_q       <= '0;
            sep_pend_q  <= 1'b0;
            snap_q      <= '0;
            Key_Flag    <= 1'b0;
            Key_Value   <= '0;
            Loaded      <= 1'b0;
            Stream_Done <= 1'b0;
`ifdef DIGIT_STREAM_SER_CLEAR_EN
            clr_pend_q  <= 1'b0;
`endif
        end else begin
            Key_Flag    <= 1'b0;
            // Only the final token leaves Key_Flag high while already back in IDLE.
            Stream_Done <= Key_Flag && (state_q == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (Load) begin
                        snap_q <= Load_Data;
                        Loaded <= 1'b1;
                    end else if (Start && Loaded) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        dig_q      <= '0;
                        pos_q      <= '0;
                        grp_q      <= '0;
                        sep_pend_q <= 1'b0;
`ifdef DIGIT_STREAM_SER_CLEAR_EN
                        clr_pend_q <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (!wrap_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q     <= '0;
                        Key_Flag  <= 1'b1;
                        Key_Value <= token_d;
`ifdef DIGIT_STREAM_SER_CLEAR_EN
                        if (clr_pend_q) clr_pend_q <= 1'b0; else
`endif
                        if (sep_pend_q) begin
                            sep_pend_q <= 1'b0;
                            grp_q      <= grp_q + 1'b1;
                        end else begin
                            if (last_d) state_q <= S_IDLE;
                            else        dig_q   <= dig_q + 1'b1;
                            if (pos_q == POS_W'(GROUP_LEN - 1)) begin
                                pos_q <= '0;
                                if (!last_d) sep_pend_q <= 1'b1;
                            end else begin
                                pos_q <= pos_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_stream_ser.sv
// tb/tb_digit_stream_ser.sv - scoreboard bench for digit_stream_ser (LSB-first and MSB-first instances)

`define CHK(tag, obs, exp) \
    begin \
        tests++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0d expected %0d", tag, (obs), (exp)); \
        end \
    end

module tb_digit_stream_ser;
    localparam int DW = 4;
    localparam int GL = 5;
    localparam int NG = 4;
    localparam int ND = GL * NG;
    localparam int P  = 4;
`ifdef DIGIT_STREAM_SER_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int NT = ND + NG - 1 + CLR;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b0;
    logic           Start = 1'b0;
    logic           Load = 1'b0;
    logic [DW*ND-1:0] Load_Data = '0;

    logic           kf0, busy0, ld0, sd0;
    logic [DW-1:0]  kv0;
    logic           kf1, busy1, ld1, sd1;
    logic [DW-1:0]  kv1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int due0 = 0;
    int done0 = -1;
    int done1 = -1;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    logic [DW*ND-1:0] d1;
    logic [DW*ND-1:0] d2;
    int last_a;
    int seventh;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    digit_stream_ser #(.PACE_CYCLES(P)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Load(Load), .Load_Data(Load_Data),
        .Key_Flag(kf0), .Key_Value(kv0), .Busy(busy0), .Loaded(ld0), .Stream_Done(sd0)
    );

    digit_stream_ser #(.PACE_CYCLES(P), .MSB_FIRST(1)) dut_msb (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Load(Load), .Load_Data(Load_Data),
        .Key_Flag(kf1), .Key_Value(kv1), .Busy(busy1), .Loaded(ld1), .Stream_Done(sd1)
    );

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic push_stream(input logic [DW*ND-1:0] d);
        int idx;
        if (CLR != 0) begin
            q0.push_back(DW'(13));
            q1.push_back(DW'(13));
        end
        for (int g = 0; g < NG; g++) begin
            for (int p = 0; p < GL; p++) begin
                idx = g * GL + p;
                q0.push_back(d[idx*DW +: DW]);
                q1.push_back(d[(ND-1-idx)*DW +: DW]);
            end
            if (g < NG - 1) begin
                q0.push_back(DW'(10 + g));
                q1.push_back(DW'(10 + g));
            end
        end
    endtask

    task automatic start_stream(input logic [DW*ND-1:0] d);
        Start = 1'b1;
        due0  = cyc + 1 + P;
        push_stream(d);
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * P * NT; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $error("FAIL drain: wait expired with %0d tokens outstanding", q0.size() + q1.size());
        end
        repeat (2) tick();
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        forever begin
            @(negedge Clk);
            if (kf0) begin
                if (q0.size() == 0) `CHK("kf0_extra", kf0, 1'b0)
                else begin
                    e = q0.pop_front();
                    `CHK("kv0", kv0, e)
                    `CHK("pace0", cyc, due0)
                    due0 += P;
                    if (q0.size() == 0) done0 = cyc + 1;
                end
            end
            if (kf1) begin
                if (q1.size() == 0) `CHK("kf1_extra", kf1, 1'b0)
                else begin
                    e = q1.pop_front();
                    `CHK("kv1_msb", kv1, e)
                    if (q1.size() == 0) done1 = cyc + 1;
                end
            end
            if (sd0 || cyc == done0) begin
                `CHK("done0", sd0, (cyc == done0))
                if (cyc == done0) done0 = -1;
            end
            if (sd1 || cyc == done1) begin
                `CHK("done1", sd1, (cyc == done1))
                if (cyc == done1) done1 = -1;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        d1 = 80'h98765432109876543210;
        for (int i = 0; i < ND; i++) d2[i*DW +: DW] = DW'($urandom_range(0, 15));

        repeat (3) tick();
        tests++;
        if (kf0 !== 1'b0 || kv0 !== 4'd0 || busy0 !== 1'b0 || ld0 !== 1'b0 || sd0 !== 1'b0 ||
            kf1 !== 1'b0 || kv1 !== 4'd0 || busy1 !== 1'b0 || ld1 !== 1'b0 || sd1 !== 1'b0) begin
            fails++;
            $error("FAIL reset state: kf=%0b kv=%0d busy=%0b loaded=%0b done=%0b", kf0, kv0, busy0, ld0, sd0);
        end
        `CHK("rst_kf", kf0, 1'b0)
        `CHK("rst_kv", kv0, 4'd0)
        `CHK("rst_busy", busy0, 1'b0)
        `CHK("rst_loaded", ld0, 1'b0)
        `CHK("rst_done", sd0, 1'b0)
        `CHK("rst_loaded_msb", ld1, 1'b0)
        Rst_n = 1'b1;
        tick();

        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (200) tick();
        `CHK("busy_noload", busy0, 1'b0)
        `CHK("loaded_noload", ld0, 1'b0)

        Load_Data = d1;
        Load = 1'b1;
        Start = 1'b1;
        tick();
        Load = 1'b0;
        Start = 1'b0;
        `CHK("loaded_ls", ld0, 1'b1)
        `CHK("busy_ls", busy0, 1'b0)
        repeat (20) tick();
        `CHK("busy_ls_late", busy0, 1'b0)

        start_stream(d1);
        last_a = due0 + P * (NT - 1);
        `CHK("busy_run", busy0, 1'b1)
        repeat (30) tick();
        Load_Data = ~d1;
        Load = 1'b1;
        Start = 1'b1;
        tick();
        Load = 1'b0;
        Start = 1'b0;
        while (cyc < last_a && cyc < last_a + 10) tick();
        `CHK("drain_a", q0.size() + q1.size(), 0)
        `CHK("busy_after_a", busy0, 1'b0)

        start_stream(d1);
        `CHK("busy_restart", busy1, 1'b1)
        wait_drain();
        `CHK("busy_idle_b", busy0, 1'b0)

        Load_Data = d2;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        start_stream(d2);
        wait_drain();

        start_stream(d2);
        seventh = due0 + 6 * P;
        while (cyc < seventh) tick();
        Rst_n = 1'b0;
        tick();
        `CHK("abort_kf", kf0, 1'b0)
        `CHK("abort_kv", kv0, 4'd0)
        `CHK("abort_busy", busy0, 1'b0)
        `CHK("abort_loaded", ld0, 1'b0)
        `CHK("abort_done", sd0, 1'b0)
        `CHK("abort_busy_msb", busy1, 1'b0)
        q0.delete();
        q1.delete();
        done0 = -1;
        done1 = -1;
        Rst_n = 1'b1;
        repeat (100) tick();
        `CHK("abort_quiet_busy", busy0, 1'b0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/digit_stream_ser.md
DIGIT_STREAM_SER -- requirements
Module: digit_stream_ser

Interface
REQ-001 Parameter DIGIT_W, default 4: bits per digit and per Key_Value code.
REQ-002 Parameter GROUP_LEN, default 5: digits per group.
REQ-003 Parameter NUM_GROUPS, default 4: groups per stream; NUM_DIGITS = GROUP_LEN*NUM_GROUPS.
REQ-004 Parameter PACE_CYCLES, default 250000: clock cycles between emitted tokens; minimum 2.
REQ-005 Parameter MSB_FIRST, default 0: 0 emits digit 0 (Load_Data[DIGIT_W-1:0]) first, 1 emits the most significant digit first.
REQ-006 Parameter SEP_BASE, default 10: separator after group g (g = 0..NUM_GROUPS-2) has code SEP_BASE+g.
REQ-007 Parameter CLEAR_CODE, default 13: code of the leading clear token.
REQ-008 Clk  input  1  sole clock, rising edge.
REQ-009 Rst_n  input  1  synchronous, active-low reset.
REQ-010 Start  input  1  single-cycle trigger, debounced upstream.
REQ-011 Load  input  1  single-cycle capture strobe for Load_Data.
REQ-012 Load_Data  input  DIGIT_W*NUM_DIGITS  packed digit vector.
REQ-013 Key_Flag  output  1  single-cycle token-valid pulse.
REQ-014 Key_Value  output  DIGIT_W  token code; holds last value between pulses.
REQ-015 Busy  output  1  high while a stream is in progress.
REQ-016 Loaded  output  1  high once a snapshot is held.
REQ-017 Stream_Done  output  1  single-cycle pulse one cycle after the last token's Key_Flag.

Function
REQ-018 States: IDLE, RUN; Busy = (state == RUN).
REQ-019 IDLE: Load=1 copies Load_Data into the snapshot register and sets Loaded in the same edge.
REQ-020 IDLE: Start=1 with Loaded=1 and Load=0 enters RUN, clears the pace counter and token index.
REQ-021 Load and Start high in the same IDLE cycle: Load is taken, Start is ignored.
REQ-022 Start with Loaded=0 is ignored; Load and Start during RUN are ignored, so the snapshot is stable for the whole stream.
REQ-023 Token sequence: digits in snapshot order, with separator SEP_BASE+g inserted after every GROUP_LEN digits, none after the last group; total NUM_DIGITS+NUM_GROUPS-1 tokens, plus the clear token per REQ-030.
REQ-024 RUN: the pace counter counts 0..PACE_CYCLES-1 and wraps; on wrap, Key_Flag=1 and Key_Value=current token are registered and the index advances.
REQ-025 The first Key_Flag is high exactly PACE_CYCLES+1 cycles after the cycle in which Start was sampled; each later Key_Flag follows its predecessor by exactly PACE_CYCLES cycles.
REQ-026 Key_Flag is 0 in every cycle except the REQ-024 pulses.
REQ-027 After the last token: return to IDLE, pulse Stream_Done in the next cycle, keep the snapshot and Loaded, and allow immediate re-Start.
REQ-028 Index and counter widths are $clog2 of their ranges; no wrap-around occurs before the last token.
REQ-029 Parameter legality: SEP_BASE+NUM_GROUPS-2 and CLEAR_CODE each SHALL be at most 2**DIGIT_W-1; an illegal setting SHALL stop elaboration with an error.

Configuration
REQ-030 Macro DIGIT_STREAM_SER_CLEAR_EN: when defined, CLEAR_CODE is token 0 of every stream, the digits follow, and all later tokens are delayed by one PACE_CYCLES slot; when undefined, the stream starts with the first digit and no clear logic is generated.

Reset
REQ-031 Rst_n=0 at a rising edge: state=IDLE, Key_Flag=0, Key_Value=0, Busy=0, Loaded=0, Stream_Done=0, snapshot=0, counter=0, index=0.
REQ-032 Reset during RUN aborts the stream with no further Key_Flag and no Stream_Done pulse.
REQ-033 Reset has priority over Load and Start in the same cycle.

Verification
REQ-034 Defaults with PACE_CYCLES=4, CLEAR_EN undefined: Load 80'h98765432109876543210, then Start -> Key_Value sequence 0,1,2,3,4,10,5,6,7,8,9,11,0,1,2,3,4,12,5,6,7,8,9; pulses 4 cycles apart; first pulse 5 cycles after Start; Stream_Done follows.
REQ-035 Same as REQ-034 with CLEAR_EN defined -> 13 first, then the REQ-034 sequence; 24 pulses.
REQ-036 MSB_FIRST=1, same data -> 9,8,7,6,5,10,4,3,2,1,0,11,9,... ending with 0.
REQ-037 Start with Loaded=0 -> no Key_Flag for 200 cycles; Load and Start in the same cycle -> Loaded=1, Busy stays 0.
REQ-038 Load of different data and a second Start mid-stream -> ignored, original sequence completes; Rst_n=0 after the 7th token -> all outputs 0 on the next edge, no further pulses.
